div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 38 +++
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
//------------------------------------------------------------------------------
// Module  : div_unit_pkg
// Purpose : Shared definitions for the multi-cycle divider: FSM state
//           encodings, DIV/DIVU aluop codes, result/ready constants and a
//           helper that converts a signed operand to its magnitude.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package div_unit_pkg;

    // Divider FSM states
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // EX-stage aluop codes that route to the divider
    localparam logic [7:0]  c_EXE_DIV_OP       = 8'b0001_1010;
    localparam logic [7:0]  c_EXE_DIVU_OP      = 8'b0001_1011;

    // Result / handshake constants
    localparam logic [63:0] c_ZERO_DWORD       = 64'h0;
    localparam logic        c_DIV_RESULT_READY = 1'b1;
    localparam logic        c_DIV_RESULT_NOT_READY = 1'b0;
    localparam logic [5:0]  c_DIV_LAST_STEP    = 6'd32;

    // Two's-complement magnitude of v when it is a negative signed value
    function automatic logic [31:0] div_magnitude(input logic [31:0] v,
                                                  input logic        is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
//------------------------------------------------------------------------------
// Module  : div_unit
// Purpose : 32-bit restoring divider for DIV/DIVU, one quotient bit per cycle.
//           Result is {remainder, quotient}; signed results are produced by
//           dividing magnitudes and fixing the signs on the final edge.
// Ports   : clk           - clock, rising edge
//           rst_n         - asynchronous active-low reset
//           signed_div_i  - 1 = signed DIV, 0 = unsigned DIVU
//           opdata1_i     - dividend
//           opdata2_i     - divisor
//           start_i       - request, held by EX until ready_o is seen
//           annul_i       - cancel an in-flight division
//           result_o      - {remainder, quotient} -> {HI, LO}
//           ready_o       - result_o valid
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  r_state,    w_state_nxt;
    logic [5:0]  r_cnt,      w_cnt_nxt;
    logic [64:0] r_dividend, w_dividend_nxt;
    logic [31:0] r_divisor,  w_divisor_nxt;
    logic        r_neg_quot, w_neg_quot_nxt;
    logic        r_neg_rem,  w_neg_rem_nxt;
    logic [63:0] w_result_nxt;
    logic        w_ready_nxt;
    logic [32:0] w_diff;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Trial subtraction of the divisor from the current partial remainder;
    // bit 32 set means the subtraction borrowed and must be discarded.
    assign w_diff = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

    // After 32 steps the quotient sits in the low word and the remainder in
    // the top 32 bits (the working register carries one extra shift slot).
    assign w_quot = r_neg_quot ? (~r_dividend[31:0]  + 32'd1) : r_dividend[31:0];
    assign w_rem  = r_neg_rem  ? (~r_dividend[64:33] + 32'd1) : r_dividend[64:33];

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_neg_quot_nxt = r_neg_quot;
        w_neg_rem_nxt  = r_neg_rem;
        w_result_nxt   = result_o;
        w_ready_nxt    = ready_o;

        case (r_state)
            DIV_FREE: begin
                w_result_nxt = c_ZERO_DWORD;
                w_ready_nxt  = c_DIV_RESULT_NOT_READY;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'h0) begin
                        w_state_nxt = DIV_BYZERO;
                    end else begin
                        w_state_nxt    = DIV_ON;
                        w_cnt_nxt      = 6'd0;
                        w_dividend_nxt = {32'h0, div_magnitude(opdata1_i, signed_div_i), 1'b0};
                        w_divisor_nxt  = div_magnitude(opdata2_i, signed_div_i);
                        w_neg_quot_nxt = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        w_neg_rem_nxt  = signed_div_i & opdata1_i[31];
                    end
                end
            end

            DIV_BYZERO: begin
                w_state_nxt    = DIV_END;
                w_dividend_nxt = 65'h0;
                w_result_nxt   = c_ZERO_DWORD;
                w_ready_nxt    = c_DIV_RESULT_READY;
            end

            DIV_ON: begin
                if (annul_i) begin
                    w_state_nxt  = DIV_FREE;
                    w_cnt_nxt    = 6'd0;
                    w_result_nxt = c_ZERO_DWORD;
                    w_ready_nxt  = c_DIV_RESULT_NOT_READY;
                end else if (r_cnt != c_DIV_LAST_STEP) begin
                    // Shift in quotient bit 0 on borrow, otherwise keep the
                    // difference as the new partial remainder and shift in 1.
                    if (w_diff[32]) begin
                        w_dividend_nxt = {r_dividend[63:0], 1'b0};
                    end else begin
                        w_dividend_nxt = {w_diff[31:0], r_dividend[31:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + 6'd1;
                end else begin
                    w_state_nxt  = DIV_END;
                    w_cnt_nxt    = 6'd0;
                    w_result_nxt = {w_rem, w_quot};
                    w_ready_nxt  = c_DIV_RESULT_READY;
                end
            end

            DIV_END: begin
                if (!start_i) begin
                    w_state_nxt  = DIV_FREE;
                    w_result_nxt = c_ZERO_DWORD;
                    w_ready_nxt  = c_DIV_RESULT_NOT_READY;
                end
            end

            default: begin
                w_state_nxt = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= DIV_FREE;
            r_cnt      <= 6'd0;
            r_dividend <= 65'h0;
            r_divisor  <= 32'h0;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
            result_o   <= c_ZERO_DWORD;
            ready_o    <= c_DIV_RESULT_NOT_READY;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_neg_quot <= w_neg_quot_nxt;
            r_neg_rem  <= w_neg_rem_nxt;
            result_o   <= w_result_nxt;
            ready_o    <= w_ready_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_div_unit
// Purpose : Self-checking bench for div_unit: vector table, random operands
//           against a reference model, annul and asynchronous reset sequences.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    // Latency counted in edges from (and including) the first edge that sees start_i
    localparam int c_LAT_DIV  = 34;
    localparam int c_LAT_ZERO = 2;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[12];
    logic [63:0] scb[$];

    div_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete request: drive, wait for ready (bounded), compare, hold, release
    task automatic run_div(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int          edges;
        logic [63:0] e;
        scb.push_back(exp);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick;
        edges = 1;
        // Operands are latched; disturbing them now must not matter
        opdata1_i    = ~a;
        opdata2_i    = b ^ 32'h5A5A_0001;
        signed_div_i = ~s;
        while (!ready_o && edges < 60) begin
            tick;
            edges++;
        end
        check({name, " latency"}, 64'(edges), 64'(lat));
        e = scb.pop_front();
        check({name, " result"}, result_o, e);
        // start held: result must stay, annul ignored in DIV_END
        annul_i = 1'b1;
        tick;
        tick;
        annul_i = 1'b0;
        check({name, " hold ready"}, 64'(ready_o), 64'd1);
        check({name, " hold result"}, result_o, e);
        start_i = 1'b0;
        tick;
        check({name, " release ready"}, 64'(ready_o), 64'd0);
        check({name, " release result"}, result_o, 64'h0);
    endtask

    task automatic no_ready_window(input string name);
        int seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (ready_o) seen++;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0]        ra, rb;
        logic signed [31:0] sa, sbv;
        logic signed [31:0] sq, sr;

        vecs[0]  = '{"u 100/7",        1'b0, 32'd100,       32'd7,         {32'd2,        32'd14},        c_LAT_DIV};
        vecs[1]  = '{"s -7/2",         1'b1, 32'hFFFFFFF9,  32'h2,         {32'hFFFFFFFF, 32'hFFFFFFFD},  c_LAT_DIV};
        vecs[2]  = '{"u -7/2",         1'b0, 32'hFFFFFFF9,  32'h2,         {32'h1,        32'h7FFFFFFC},  c_LAT_DIV};
        vecs[3]  = '{"u 5/0",          1'b0, 32'd5,         32'd0,         64'h0,                         c_LAT_ZERO};
        vecs[4]  = '{"s ovf",          1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h0,        32'h80000000},  c_LAT_DIV};
        vecs[5]  = '{"u 9/3",          1'b0, 32'd9,         32'd3,         {32'h0,        32'h3},         c_LAT_DIV};
        vecs[6]  = '{"s 7/-2",         1'b1, 32'd7,         32'hFFFFFFFE,  {32'h1,        32'hFFFFFFFD},  c_LAT_DIV};
        vecs[7]  = '{"s -7/-2",        1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  {32'hFFFFFFFF, 32'h3},         c_LAT_DIV};
        vecs[8]  = '{"u max/1",        1'b0, 32'hFFFFFFFF,  32'h1,         {32'h0,        32'hFFFFFFFF},  c_LAT_DIV};
        vecs[9]  = '{"u 1/max",        1'b0, 32'h1,         32'hFFFFFFFF,  {32'h1,        32'h0},         c_LAT_DIV};
        vecs[10] = '{"s -5/0",         1'b1, 32'hFFFFFFFB,  32'h0,         64'h0,                         c_LAT_ZERO};
        vecs[11] = '{"u max/max",      1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  {32'h0,        32'h1},         c_LAT_DIV};

        rst_n        = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        tick;
        tick;
        check("reset result", result_o, 64'h0);
        check("reset ready", 64'(ready_o), 64'd0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Random unsigned operands against the language's own / and %
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'h0) rb = 32'h1;
            run_div("rand u", 1'b0, ra, rb, {ra % rb, ra / rb}, c_LAT_DIV);
        end
        // Random signed operands (truncating division, remainder follows dividend)
        for (int i = 0; i < 4; i++) begin
            sa  = $signed($urandom);
            sbv = $signed($urandom >> $urandom_range(0, 28));
            if ($urandom_range(0, 1) == 1) sbv = -sbv;
            if (sbv == 0 || sbv == -1) sbv = 32'sd3;
            sq = sa / sbv;
            sr = sa % sbv;
            run_div("rand s", 1'b1, sa, sbv, {sr, sq}, c_LAT_DIV);
        end

        // Annul at step 10, then a fresh request must run normally
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        tick;
        for (int i = 0; i < 10; i++) tick;
        annul_i = 1'b1;
        tick;
        check("annul ready", 64'(ready_o), 64'd0);
        check("annul result", result_o, 64'h0);
        annul_i = 1'b0;
        start_i = 1'b0;
        no_ready_window("annul no ready");
        run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, c_LAT_DIV);

        // Asynchronous reset in the middle of DIV_ON
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFFFFF9;
        opdata2_i    = 32'h2;
        start_i      = 1'b1;
        tick;
        for (int i = 0; i < 14; i++) tick;
        #2 rst_n = 1'b0;
        #1;
        check("rst mid ready", 64'(ready_o), 64'd0);
        check("rst mid result", result_o, 64'h0);
        start_i = 1'b0;
        #3 rst_n = 1'b1;
        no_ready_window("rst mid no ready");

        // Asynchronous reset while a result is held in DIV_END: clears without a clock edge
        signed_div_i = 1'b0;
        opdata1_i    = 32'd9;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        begin
            int edges = 0;
            while (!ready_o && edges < 60) begin
                tick;
                edges++;
            end
        end
        check("pre-rst end ready", 64'(ready_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst end ready", 64'(ready_o), 64'd0);
        check("rst end result", result_o, 64'h0);
        start_i = 1'b0;
        #3 rst_n = 1'b1;
        no_ready_window("rst end no ready");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
